// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: samples x once per divider tick, tracks the
// longest matched prefix of PATTERN and shows progress or match count on a 7-segment display.
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1000,
    parameter bit                 OVERLAP   = 1'b1,
    parameter int                 DIV_COUNT = 20000000,
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             disp_sel,
    output logic             tick_led,
    output logic             match,
    output logic             det,
    output logic [3:0]       progress,
    output logic [CNT_W-1:0] match_cnt,
    output logic [6:0]       seg
);

    localparam int               DIV_W    = $clog2(DIV_COUNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
    localparam logic [3:0]       PLEN     = 4'(PAT_LEN);

    // Bit j of the pattern in arrival order (j = 0 is the first bit expected).
    function automatic logic pat_bit(input int j);
        logic [31:0] t;
        t = 32'(PATTERN) >> (PAT_LEN - 1 - j);
        return t[0];
    endfunction

    // Longest prefix of PATTERN that is a suffix of (first p pattern bits, then b).
    function automatic int next_len(input int p, input logic b);
        int   best;
        int   ti;
        logic ok;
        logic tb;
        best = 0;
        for (int l = 1; l <= p + 1 && l <= PAT_LEN; l++) begin
            ok = 1'b1;
            for (int k = 0; k < l; k++) begin
                ti = p + 1 - l + k;
                tb = (ti == p) ? b : pat_bit(ti);
                if (tb != pat_bit(k)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Longest proper border of the whole pattern: where overlapping detection resumes.
    function automatic int border_len();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < PAT_LEN; l++) begin
            ok = 1'b1;
            for (int k = 0; k < l; k++)
                if (pat_bit(k) != pat_bit(PAT_LEN - l + k)) ok = 1'b0;
            if (ok) best = l;
        end
        return best;
    endfunction

    localparam logic [3:0] BORDER = 4'(border_len());

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_p;
    logic             r_tick;
    logic             r_match;
    logic             r_det;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_seg;

    logic [3:0] w_nxt0 [16];
    logic [3:0] w_nxt1 [16];
    logic [3:0] w_cand;
    logic [3:0] w_cnt_nib;
    logic [3:0] w_nib;
    logic       w_sample;
    logic       w_full;

    // Full transition table (KMP fallback folded in) resolved at elaboration.
    for (genvar gp = 0; gp < 16; gp++) begin : g_nxt
        if (gp < PAT_LEN) begin : g_used
            localparam logic [3:0] N0 = 4'(next_len(gp, 1'b0));
            localparam logic [3:0] N1 = 4'(next_len(gp, 1'b1));
            assign w_nxt0[gp] = N0;
            assign w_nxt1[gp] = N1;
        end else begin : g_unused
            assign w_nxt0[gp] = 4'd0;
            assign w_nxt1[gp] = 4'd0;
        end
    end

    if (CNT_W >= 4) begin : g_nib_wide
        assign w_cnt_nib = r_cnt[3:0];
    end else begin : g_nib_narrow
        assign w_cnt_nib = 4'(r_cnt);
    end

    assign w_sample = (r_div == DIV_LAST);
    assign w_cand   = x ? w_nxt1[r_p] : w_nxt0[r_p];
    assign w_full   = (w_cand == PLEN);
    assign w_nib    = disp_sel ? w_cnt_nib : r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_p     <= 4'd0;
            r_tick  <= 1'b0;
            r_match <= 1'b0;
            r_det   <= 1'b0;
            r_cnt   <= '0;
            r_seg   <= 7'b0000001;
        end else begin
            r_div   <= w_sample ? '0 : r_div + 1'b1;
            r_match <= 1'b0;
            r_seg   <= hex7(w_nib);
            if (w_sample) begin
                r_tick <= ~r_tick;
                if (w_full) begin
                    r_match <= 1'b1;
                    r_det   <= 1'b1;
                    r_cnt   <= r_cnt + 1'b1;
                    r_p     <= OVERLAP ? BORDER : 4'd0;
                end else begin
                    r_det   <= 1'b0;
                    r_p     <= w_cand;
                end
            end
        end
    end

    assign tick_led  = r_tick;
    assign match     = r_match;
    assign det       = r_det;
    assign progress  = r_p;
    assign match_cnt = r_cnt;
    assign seg       = r_seg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three detector configurations share one stimulus stream
// and are compared against a bit-history model of the prefix/suffix definition.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0;
    logic disp_sel = 1'b0;

    always #5 clk = ~clk;

    logic       tl0, tl1, tl2, m0, m1, m2, d0, d1, d2;
    logic [3:0] pr0, pr1, pr2;
    logic [7:0] mc0, mc2;
    logic [3:0] mc1;
    logic [6:0] sg0, sg1, sg2;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1000), .OVERLAP(1'b1), .DIV_COUNT(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .x(x), .disp_sel(disp_sel), .tick_led(tl0), .match(m0),
        .det(d0), .progress(pr0), .match_cnt(mc0), .seg(sg0));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .DIV_COUNT(4), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .x(x), .disp_sel(disp_sel), .tick_led(tl1), .match(m1),
        .det(d1), .progress(pr1), .match_cnt(mc1), .seg(sg1));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .DIV_COUNT(4), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .x(x), .disp_sel(disp_sel), .tick_led(tl2), .match(m2),
        .det(d2), .progress(pr2), .match_cnt(mc2), .seg(sg2));

    int checks = 0;
    int failures = 0;
    int pre = 4;
    bit rand_ds = 1'b1;

    int pat [3] = '{8, 10, 10};
    int len [3] = '{4, 4, 4};
    int ov  [3] = '{1, 1, 0};
    int cw  [3] = '{8, 4, 8};
    int hist[3], hlen[3], mp[3], mcnt[3], mdet[3], mmatch[3];
    int mtl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int n);
        case (n & 15)
            0: return 7'b0000001;   1: return 7'b1001111;
            2: return 7'b0010010;   3: return 7'b0000110;
            4: return 7'b1001100;   5: return 7'b0100100;
            6: return 7'b0100000;   7: return 7'b0001111;
            8: return 7'b0000000;   9: return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Longest L <= maxl such that the last L history bits equal the first L pattern bits.
    function automatic int longest(input int pt, input int ln, input int h, input int hl, input int maxl);
        for (int l = maxl; l >= 1; l--)
            if (l <= hl && ((h & ((1 << l) - 1)) == (pt >> (ln - l)))) return l;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = 0; hlen[i] = 0; mp[i] = 0; mcnt[i] = 0; mdet[i] = 0; mmatch[i] = 0;
        end
        mtl = 0;
    endtask

    task automatic model_tick(input bit b);
        int l;
        for (int i = 0; i < 3; i++) begin
            hist[i] = ((hist[i] << 1) | int'(b)) & 16'hFFFF;
            if (hlen[i] < 16) hlen[i]++;
            l = longest(pat[i], len[i], hist[i], hlen[i], len[i]);
            if (l == len[i]) begin
                mmatch[i] = 1; mdet[i] = 1;
                mcnt[i] = (mcnt[i] + 1) % (1 << cw[i]);
                if (ov[i] != 0) mp[i] = longest(pat[i], len[i], hist[i], hlen[i], len[i] - 1);
                else begin hist[i] = 0; hlen[i] = 0; mp[i] = 0; end
            end else begin
                mmatch[i] = 0; mdet[i] = 0; mp[i] = l;
            end
        end
        mtl ^= 1;
    endtask

    task automatic check_state(input int i, input logic [31:0] p_, input logic [31:0] m_,
                               input logic [31:0] d_, input logic [31:0] c_, input logic [31:0] t_);
        chk($sformatf("progress%0d", i), p_, mp[i]);
        chk($sformatf("match%0d", i), m_, mmatch[i]);
        chk($sformatf("det%0d", i), d_, mdet[i]);
        chk($sformatf("match_cnt%0d", i), c_, mcnt[i]);
        chk($sformatf("tick_led%0d", i), t_, mtl);
    endtask

    task automatic check_post(input int i, input logic [31:0] p_, input logic [31:0] m_,
                              input logic [31:0] s_);
        chk($sformatf("hold_progress%0d", i), p_, mp[i]);
        chk($sformatf("match_pulse_end%0d", i), m_, 0);
        chk($sformatf("seg%0d", i), s_, enc(disp_sel ? (mcnt[i] & 15) : mp[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        pre = 4;
        check_state(0, pr0, m0, d0, mc0, tl0);
        check_state(1, pr1, m1, d1, mc1, tl1);
        check_state(2, pr2, m2, d2, mc2, tl2);
        chk("reset_seg0", sg0, 7'b0000001);
    endtask

    task automatic do_tick(input bit b);
        x = b;
        if (rand_ds) disp_sel = 1'($urandom_range(0, 1));
        repeat (pre) @(posedge clk);
        #1;
        model_tick(b);
        check_state(0, pr0, m0, d0, mc0, tl0);
        check_state(1, pr1, m1, d1, mc1, tl1);
        check_state(2, pr2, m2, d2, mc2, tl2);
        @(posedge clk);
        #1;
        check_post(0, pr0, m0, sg0);
        check_post(1, pr1, m1, sg1);
        check_post(2, pr2, m2, sg2);
        pre = 3;
    endtask

    task automatic run_seq(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) do_tick(bits[k]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset landing on the would-be sample edge must win over the tick.
        x = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_on_tick_led", tl0, 0);
        chk("rst_on_tick_prog", pr0, 0);
        do_reset();

        run_seq(32'b1000, 4);
        chk("seq1000_cnt", mc0, 1);
        do_reset();
        run_seq(32'b11001000, 8);
        chk("seq11001000_cnt", mc0, 1);
        do_reset();
        run_seq(32'b101010, 6);
        chk("ovl_cnt", mc1, 2);
        chk("ovl_prog", pr1, 2);
        chk("novl_cnt", mc2, 1);
        chk("novl_prog", pr2, 2);

        do_reset();
        run_seq(32'b100, 3);
        chk("pre_rst_prog", pr0, 3);
        do_reset();
        do_tick(1'b0);
        chk("post_rst_prog", pr0, 0);
        chk("post_rst_match", m0, 0);

        do_reset();
        rand_ds = 1'b0;
        disp_sel = 1'b1;
        for (int r = 0; r < 17; r++) run_seq(32'b1000, 4);
        chk("cnt17", mc0, 17);
        chk("seg17", sg0, 7'b1001111);

        do_reset();
        for (int r = 0; r < 17; r++) run_seq(32'b10, 2);
        chk("wrap16", mc1, 0);
        rand_ds = 1'b1;

        do_reset();
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            do_tick(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
